// File: rtl/adc_stat_pkg.sv
// rtl/adc_stat_pkg.sv - shared widths, FSM/bin enums and the bin classifier
// Purpose: common definitions for the ADC statistics monitor.
// Ports: none (package).
package adc_stat_pkg;

  localparam int ADC_W    = 8;
  localparam int NAVG_W   = 4;
  localparam int NAVG_MAX = 10;
  localparam int SUM_W    = ADC_W + NAVG_MAX;
  localparam int HIST_W   = NAVG_MAX + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, PUBLISH = 2'd2} state_t;
  typedef enum logic [1:0] {NONE = 2'd0, CENTER = 2'd1, SIDE = 2'd2} bin_class_t;

  // The difference is formed one bit wider than the codes, so |din - nbin|
  // reaches 255 at the extremes without wrapping.
  function automatic bin_class_t bin_classify(input logic signed [ADC_W-1:0] din,
                                              input logic signed [ADC_W-1:0] nbin,
                                              input logic [ADC_W-2:0]        dz);
    logic signed [ADC_W:0] diff;
    logic [ADC_W:0]        d;
    diff = {din[ADC_W-1], din} - {nbin[ADC_W-1], nbin};
    d    = diff[ADC_W] ? $unsigned(-diff) : $unsigned(diff);
    if (d <= {2'b00, dz})
      return CENTER;
    else if (d <= {1'b0, dz, 1'b1})
      return SIDE;
    else
      return NONE;
  endfunction

endpackage

// File: rtl/adc_stat_if.sv
// rtl/adc_stat_if.sv - sample stream and published statistics bundle
// Purpose: groups the sample stream and the snapshot outputs.
// Signals: din/din_valid (sample stream), sum_out, avg_out, hist_center,
//          hist_side, done (snapshot registers and update pulse).
// Modports: master = sample source / readback, slave = monitor.
interface adc_stat_if;
  import adc_stat_pkg::*;

  logic signed [ADC_W-1:0] din;
  logic                    din_valid;
  logic signed [SUM_W-1:0] sum_out;
  logic signed [ADC_W-1:0] avg_out;
  logic [HIST_W-1:0]       hist_center;
  logic [HIST_W-1:0]       hist_side;
  logic                    done;

  modport master (output din, din_valid,
                  input  sum_out, avg_out, hist_center, hist_side, done);
  modport slave  (input  din, din_valid,
                  output sum_out, avg_out, hist_center, hist_side, done);

endinterface

// File: rtl/adc_stat_hist_bin.sv
// rtl/adc_stat_hist_bin.sv - centre/side bin classifier with saturating counters
// Purpose: classifies each accepted sample against the latched centre code and
//          dead zone and counts centre and side hits for the current window.
// Ports: clk, rst (sync, active high), clr (window restart), en (sample
//        accepted), din, nbin, dz (latched config), ctr_cnt, side_cnt (counts).
module adc_stat_hist_bin
  import adc_stat_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [ADC_W-1:0] din,
  input  logic signed [ADC_W-1:0] nbin,
  input  logic [ADC_W-2:0]        dz,
  output logic [HIST_W-1:0]       ctr_cnt,
  output logic [HIST_W-1:0]       side_cnt
);

  localparam logic [HIST_W-1:0] CNT_MAX = '1;

  bin_class_t cls;

  always_comb cls = bin_classify(din, nbin, dz);

  // Saturation is unreachable for legal window lengths; it stays as a guard.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ctr_cnt  <= '0;
      side_cnt <= '0;
    end else if (en) begin
      if (cls == CENTER && ctr_cnt != CNT_MAX)
        ctr_cnt <= ctr_cnt + HIST_W'(1);
      if (cls == SIDE && side_cnt != CNT_MAX)
        side_cnt <= side_cnt + HIST_W'(1);
    end
  end

endmodule

// File: rtl/adc_stat_monitor.sv
// rtl/adc_stat_monitor.sv - windowed sum/mean/histogram engine for one ADC slice
// Purpose: accumulates 2^Navg valid samples per window and publishes a
//          coherent snapshot (sum, mean, centre/side counts) with a done pulse.
// Ports: clk, rst (sync, active high), bus (adc_stat_if.slave: din, din_valid,
//        sum_out, avg_out, hist_center, hist_side, done), Navg, Nbin, DZ
//        (config, latched at window start).
// Optional: ADC_STAT_FREEZE_EN adds freeze (hold snapshot) and overrun (sticky).
module adc_stat_monitor
  import adc_stat_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  adc_stat_if.slave               bus,
  input  logic [NAVG_W-1:0]       Navg,
  input  logic signed [ADC_W-1:0] Nbin,
  input  logic [ADC_W-2:0]        DZ
`ifdef ADC_STAT_FREEZE_EN
  ,
  input  logic                    freeze,
  output logic                    overrun
`endif
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ACCUM   = ACCUM;
  localparam logic [1:0] S_PUBLISH = PUBLISH;

  logic [1:0]              state;
  logic [NAVG_W-1:0]       navg_l;
  logic signed [ADC_W-1:0] nbin_l;
  logic [ADC_W-2:0]        dz_l;
  logic signed [SUM_W-1:0] acc;
  logic signed [SUM_W-1:0] acc_shr;
  logic [HIST_W-1:0]       cnt;
  logic [HIST_W-1:0]       cnt_target;
  logic [HIST_W-1:0]       ctr_cnt;
  logic [HIST_W-1:0]       side_cnt;
  logic [NAVG_W-1:0]       navg_clamped;
  logic                    sample_en;
  logic                    latch_en;
  logic                    pub_update;

  always_comb begin
    navg_clamped = (Navg > NAVG_W'(NAVG_MAX)) ? NAVG_W'(NAVG_MAX) : Navg;
    cnt_target   = HIST_W'(1) << navg_l;
    acc_shr      = acc >>> navg_l;
    sample_en    = (state == S_ACCUM) && bus.din_valid;
    latch_en     = (state == S_IDLE) || (state == S_PUBLISH);
`ifdef ADC_STAT_FREEZE_EN
    pub_update   = (state == S_PUBLISH) && !freeze;
`else
    pub_update   = (state == S_PUBLISH);
`endif
  end

  // Config is only sampled at window boundaries so a window is self-consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      navg_l <= '0;
      nbin_l <= '0;
      dz_l   <= '0;
    end else if (latch_en) begin
      navg_l <= navg_clamped;
      nbin_l <= Nbin;
      dz_l   <= DZ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE:  state <= S_ACCUM;
        S_ACCUM: begin
          if (bus.din_valid) begin
            acc <= acc + $signed({{(SUM_W-ADC_W){bus.din[ADC_W-1]}}, bus.din});
            cnt <= cnt + HIST_W'(1);
            if (cnt + HIST_W'(1) == cnt_target)
              state <= S_PUBLISH;
          end
        end
        S_PUBLISH: begin
          acc   <= '0;
          cnt   <= '0;
          state <= S_ACCUM;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum_out     <= '0;
      bus.avg_out     <= '0;
      bus.hist_center <= '0;
      bus.hist_side   <= '0;
      bus.done        <= 1'b0;
    end else begin
      bus.done <= pub_update;
      if (pub_update) begin
        bus.sum_out     <= acc;
        bus.avg_out     <= acc_shr[ADC_W-1:0];
        bus.hist_center <= ctr_cnt;
        bus.hist_side   <= side_cnt;
      end
    end
  end

`ifdef ADC_STAT_FREEZE_EN
  // Records that at least one window result was discarded while frozen.
  always_ff @(posedge clk) begin
    if (rst)
      overrun <= 1'b0;
    else if (state == S_PUBLISH && freeze)
      overrun <= 1'b1;
  end
`endif

  adc_stat_hist_bin u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == S_PUBLISH),
    .en       (sample_en),
    .din      (bus.din),
    .nbin     (nbin_l),
    .dz       (dz_l),
    .ctr_cnt  (ctr_cnt),
    .side_cnt (side_cnt)
  );

endmodule

// File: tb/tb_adc_stat_monitor.sv
// tb/tb_adc_stat_monitor.sv - self-checking bench for adc_stat_monitor
module tb_adc_stat_monitor;
  import adc_stat_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NAVG_W-1:0]       navg = 4'd3;
  logic signed [ADC_W-1:0] nbin = '0;
  logic [ADC_W-2:0]        dz = '0;
`ifdef ADC_STAT_FREEZE_EN
  logic                    freeze = 1'b0;
  logic                    overrun;
`endif

  adc_stat_if bus ();

  always #5 clk = ~clk;

  adc_stat_monitor dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .Navg    (navg),
    .Nbin    (nbin),
    .DZ      (dz)
`ifdef ADC_STAT_FREEZE_EN
    ,
    .freeze  (freeze),
    .overrun (overrun)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  // Reference state: expected snapshot plus the samples of the open window.
  longint m_sum = 0, m_avg = 0, m_hc = 0, m_hs = 0;
  bit     m_done = 0, m_ovr = 0;
  bit     m_started = 0, m_pub = 0;
  int     m_n = 0, m_nbin = 0, m_dz = 0;
  int     win[$];

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void latch_cfg();
    m_n    = (int'(navg) > NAVG_MAX) ? NAVG_MAX : int'(navg);
    m_nbin = int'(nbin);
    m_dz   = int'(dz);
  endfunction

  function automatic void close_window();
    longint s = 0;
    longint div = longint'(1) << m_n;
    int hc = 0, hs = 0;
    foreach (win[i]) begin
      int d = win[i] - m_nbin;
      if (d < 0) d = -d;
      s += win[i];
      if (d <= m_dz) hc++;
      else if (d <= 2 * m_dz + 1) hs++;
    end
    m_sum  = s;
    m_avg  = (s >= 0) ? s / div : -((-s + div - 1) / div);
    m_hc   = hc;
    m_hs   = hs;
    m_done = 1;
  endfunction

  // Applied at each rising edge, from the inputs the DUT sees at that edge.
  function automatic void model_edge();
    bit frz = 0;
`ifdef ADC_STAT_FREEZE_EN
    frz = freeze;
`endif
    m_done = 0;
    if (rst) begin
      m_sum = 0; m_avg = 0; m_hc = 0; m_hs = 0; m_ovr = 0;
      m_started = 0; m_pub = 0;
      win.delete();
    end else if (!m_started) begin
      latch_cfg();
      m_started = 1;
    end else if (m_pub) begin
      n_cmp++;
      assert (!bus.din_valid) else begin
        n_bad++;
        $display("FAIL publish_idle: din_valid=%0d, expected 0", bus.din_valid);
      end
      if (frz) m_ovr = 1;
      else close_window();
      win.delete();
      latch_cfg();
      m_pub = 0;
    end else if (bus.din_valid) begin
      win.push_back(int'(bus.din));
      if (win.size() == (1 << m_n)) m_pub = 1;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sum_out", bus.sum_out, m_sum);
      chk("avg_out", bus.avg_out, m_avg);
      chk("hist_center", bus.hist_center, m_hc);
      chk("hist_side", bus.hist_side, m_hs);
      chk("done", bus.done, m_done);
`ifdef ADC_STAT_FREEZE_EN
      chk("overrun", overrun, m_ovr);
`endif
    end
  end

  task automatic tick(input bit v, input int d);
    bus.din_valid = v;
    bus.din = ADC_W'(d);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic send(input int d);
    if (m_pub || !m_started) tick(0, 0);
    tick(1, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0);
    tick(0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int neg_seq[4]  = '{-1, -2, -1, -1};
    int hist_seq[8] = '{8, 10, 12, 13, 15, 16, 7, 20};
    bus.din_valid = 1'b0;
    bus.din = '0;
    @(negedge clk);
    do_reset();
    chk_on = 1;
    chk("reset_sum", bus.sum_out, 0);
    chk("reset_done", bus.done, 0);

    // Constant input, done latency
    navg = 3; nbin = 0; dz = 0;
    do_reset();
    repeat (8) send(5);
    chk("t1_done_early", bus.done, 0);
    tick(0, 0);
    chk("t1_done", bus.done, 1);
    chk("t1_sum", bus.sum_out, 40);
    chk("t1_avg", bus.avg_out, 5);
    tick(0, 0);
    chk("t1_done_single", bus.done, 0);

    // Negative mean floors toward -inf
    navg = 2;
    do_reset();
    foreach (neg_seq[i]) send(neg_seq[i]);
    tick(0, 0);
    chk("t2_sum", bus.sum_out, -5);
    chk("t2_avg", bus.avg_out, -2);
    chk("t2_done", bus.done, 1);

    // Histogram classes: d = 2,0,2,3,5,6,3,10 with DZ=2 (side bound 5)
    navg = 3; nbin = 10; dz = 2;
    do_reset();
    foreach (hist_seq[i]) send(hist_seq[i]);
    tick(0, 0);
    chk("t3_center", bus.hist_center, 3);
    chk("t3_side", bus.hist_side, 3);
    chk("t3_avg", bus.avg_out, 12);

    // Extreme difference d=255, DZ=0 exact and d=1 boundaries
    navg = 0; nbin = 127; dz = 127;
    do_reset();
    send(-128);
    tick(0, 0);
    chk("t4_wide_side", bus.hist_side, 1);
    chk("t4_avg", bus.avg_out, -128);
    dz = 0;
    send(127);
    tick(0, 0);
    send(126);
    tick(0, 0);
    chk("t4_dz0_side", bus.hist_side, 1);
    chk("t4_dz0_center", bus.hist_center, 0);

    // Config isolation: Navg change mid-window applies to the next window
    navg = 3; nbin = 0; dz = 1;
    do_reset();
    repeat (4) send(1);
    navg = 1;
    repeat (4) send(1);
    tick(0, 0);
    chk("t5_done8", bus.done, 1);
    chk("t5_sum8", bus.sum_out, 8);
    send(2);
    send(3);
    tick(0, 0);
    chk("t5_done2", bus.done, 1);
    chk("t5_sum2", bus.sum_out, 5);
    chk("t5_avg2", bus.avg_out, 2);

    // Navg clamp to a 1024-sample window
    navg = 15;
    do_reset();
    repeat (1023) send(3);
    tick(0, 0);
    chk("t6_not_yet", bus.done, 0);
    send(3);
    tick(0, 0);
    chk("t6_done", bus.done, 1);
    chk("t6_sum", bus.sum_out, 3072);

    // Reset mid-window discards the partial window
    navg = 3;
    do_reset();
    repeat (8) send(5);
    tick(0, 0);
    repeat (5) send(7);
    rst = 1'b1;
    tick(0, 0);
    rst = 1'b0;
    chk("t7_sum_cleared", bus.sum_out, 0);
    repeat (7) send(7);
    tick(0, 0);
    chk("t7_no_done", bus.done, 0);
    send(7);
    tick(0, 0);
    chk("t7_done", bus.done, 1);
    chk("t7_sum", bus.sum_out, 56);

`ifdef ADC_STAT_FREEZE_EN
    navg = 1;
    do_reset();
    send(2); send(4);
    tick(0, 0);
    freeze = 1'b1;
    send(10); send(10);
    tick(0, 0);
    chk("frz_hold", bus.sum_out, 6);
    chk("frz_overrun", overrun, 1);
    freeze = 1'b0;
    send(1); send(1);
    tick(0, 0);
    chk("frz_release", bus.sum_out, 2);
    chk("frz_sticky", overrun, 1);
`endif

    // Randomized traffic with config changes and occasional resets
    for (int c = 0; c < 3000; c++) begin
      int d;
      bit v;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        tick(0, 0);
        rst = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) begin
        navg = NAVG_W'($urandom_range(0, 4));
        nbin = ADC_W'($urandom_range(0, 255));
        dz   = (ADC_W-1)'($urandom_range(0, 8));
      end
      if ($urandom_range(0, 1) == 0) begin
        d = int'(nbin) + int'($urandom_range(0, 24)) - 12;
        if (d > 127) d = 127;
        if (d < -128) d = -128;
      end else begin
        d = int'($urandom_range(0, 255)) - 128;
      end
      v = ($urandom_range(0, 9) < 7) && m_started && !m_pub;
      tick(v, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
